mmu_bus_arbiter: RTL and testbench
==================================

Name: mmu_bus_arbiter

Overview:
- Shares one physical memory bus port between two MMU-side masters: M0 = instruction-fetch MMU, M1 = data-access MMU. Both masters use the same req/gnt/hrd/a/d/we/rd/spo/ready bus protocol.
- Sits between the two mmu_sv32 physical-side ports and the system bus interconnect.
- Ownership is sticky for the whole multi-access sequence: page-table walk, A/D taint and final access.
- Priority is round-robin, with a fairness cap so one master cannot starve the other.

Parameters:
- MAX_XFER, 8, completed transfers an owner may perform while the other master waits; after that the owner is forced off the bus.
- CNT_W, 4, width of the transfer counter; must satisfy 2**CNT_W > MAX_XFER.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_req[0..1]  in  1 each  master bus request
- m_gnt[0..1]  out  1 each  grant to master
- m_hrd[0..1]  out  1 each  hold/retract to master; the master must drop rd/we while it is high
- m_a[0..1]  in  32 each  master address
- m_d[0..1]  in  32 each  master write data
- m_we[0..1]  in  1 each  master write strobe
- m_rd[0..1]  in  1 each  master read strobe
- m_spo[0..1]  out  32 each  read data to master
- m_ready[0..1]  out  1 each  transfer-complete strobe to master
- s_req  out  1  downstream request
- s_gnt  in  1  downstream grant
- s_hrd  in  1  downstream hold
- s_a  out  32  muxed address
- s_d  out  32  muxed write data
- s_we  out  1  muxed write strobe
- s_rd  out  1  muxed read strobe
- s_spo  in  32  downstream read data
- s_ready  in  1  downstream transfer complete

Behaviour:
- Reset (async assert, sync deassert on clk) puts the block in this state:
  - state=IDLE, last=1 (so M0 wins first), cnt=0.
  - All m_gnt=0, m_hrd=0, m_ready=0.
  - s_req=0, s_we=0, s_rd=0, s_a=0, s_d=0.
- States: IDLE, OWN0, OWN1, DRAIN.
- IDLE:
  - One requester → go to its OWNx next cycle.
  - Both requesting → grant the one not equal to last.
  - No requester → stay in IDLE.
  - Arbitration costs 1 cycle of latency; there is no combinational req→gnt path.
- OWNx, outputs:
  - m_gnt[x]=s_gnt, m_hrd[x]=s_hrd.
  - s_req=m_req[x]; s_a/s_d/s_we/s_rd come from master x.
  - m_ready[x]=s_ready; m_spo[x]=s_spo.
  - Non-owner sees gnt=0, hrd=1, ready=0.
  - m_spo to both masters is always s_spo; only ready is gated.
- OWNx, counting: cnt increments on each cycle with (s_rd|s_we)&s_gnt&s_ready. cnt saturates at MAX_XFER.
- OWNx exits:
  - m_req[x]=0 with no strobe active → set last=x, cnt=0, go to IDLE.
  - Other master requesting and cnt==MAX_XFER → go to DRAIN.
- DRAIN:
  - Owner's m_hrd forced to 1 and s_we/s_rd forced to 0.
  - The completing transfer is never cut: the move to DRAIN is only taken on the cycle after a ready, so no strobe is in flight.
  - Next cycle: last=x, cnt=0, go to OWN of the other master.
- Owner requesting alone never hits the cap: cnt is ignored while the other m_req=0.
- Simultaneous events:
  - Owner drops req on the same cycle the cap is reached → the IDLE path wins.
  - New request while in DRAIN → waits for normal arbitration.
- Reset mid-transfer drops s_rd/s_we immediately; the downstream slave must tolerate the abandoned strobe.
- The rd/we strobes of a non-owner are ignored entirely.

Decomposition:
- Shared package/header gets:
  - the state encodings for IDLE/OWN0/OWN1/DRAIN;
  - a bus-bundle width constant BUS_AW=32, BUS_DW=32.
- One natural sub-module: rr_pick2. It is a 2-way round-robin chooser: inputs req[1:0] and last, output winner index and a valid flag. It is purely combinational and reusable by other 2-master arbiters.
- FSM, counter and muxing stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with both m_req=1 → all gnt/ready=0, s_req=0. Release → M0 owns 1 cycle later; s_a equals m_a[0] (e.g. 0x8000_0010).
- Sticky walk: M1 issues 3 reads (pteaddr1, pteaddr2, data) with req held; M0 requests meanwhile → M1 keeps ownership for all 3. M0 is granted 1 cycle after M1 drops req. m_ready[0] is never seen during M1's reads.
- Fairness cap (MAX_XFER=8): M0 streams reads continuously while M1 requests → exactly 8 s_ready pulses to M0, then 1 DRAIN cycle with m_hrd[0]=1, then M1 owns.
- Tie-break: both request from IDLE with last=0 → M1 wins. Repeat with last=1 → M0 wins.
- Downstream hold: s_hrd=1 during OWN1 → m_hrd[1]=1 and m_hrd[0]=1. Owner is unchanged. cnt does not increment.
- Async reset mid-write (s_we=1, before s_ready) → s_we goes low in the same timestep as rst_n falls. State returns to IDLE and cnt=0.

Source files
------------

// File: rtl/mmu_bus_arbiter_pkg.sv
// mmu_bus_arbiter_pkg: shared types and widths for the MMU bus arbiter.
// Provides the FSM state encoding and the physical bus address/data widths.
package mmu_bus_arbiter_pkg;

   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN0  = 2'd1,
      ST_OWN1  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/mmu_bus_arbiter_if.sv
// mmu_bus_arbiter_if: one req/gnt/hrd physical memory bus port.
// master drives req/a/d/we/rd; slave drives gnt/hrd/spo/ready.
interface mmu_bus_arbiter_if;
   import mmu_bus_arbiter_pkg::*;

   logic              req;
   logic              gnt;
   logic              hrd;
   logic [BUS_AW-1:0] a;
   logic [BUS_DW-1:0] d;
   logic              we;
   logic              rd;
   logic [BUS_DW-1:0] spo;
   logic              ready;

   modport master (
      output req, a, d, we, rd,
      input  gnt, hrd, spo, ready
   );

   modport slave (
      input  req, a, d, we, rd,
      output gnt, hrd, spo, ready
   );

endinterface

// File: rtl/mmu_bus_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin chooser.
// Ports: req[1:0] requests, last = previous owner; winner index, valid.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

   always_comb begin
      winner = 1'b0;
      unique case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last;
         default: winner = 1'b0;
      endcase
   end

   assign valid = |req;

endmodule

// File: rtl/mmu_bus_arbiter.sv
// mmu_bus_arbiter: shares one memory bus between two MMU masters.
// Ports: clk, rst_n, m0/m1 (slave side of each MMU), s (downstream bus).
module mmu_bus_arbiter
   import mmu_bus_arbiter_pkg::*;
#(
   parameter int MAX_XFER = 8,
   parameter int CNT_W    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   mmu_bus_arbiter_if.slave    m0,
   mmu_bus_arbiter_if.slave    m1,
   mmu_bus_arbiter_if.master   s
);

   localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_XFER);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t            state, state_nxt;
   logic              last, last_nxt;
   logic              owner, owner_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CNT_W-1:0]  cnt_inc;

   logic [1:0]        req, we, rd;
   logic [BUS_AW-1:0] a [2];
   logic [BUS_DW-1:0] d [2];
   logic [1:0]        gnt, hrd, ready;

   logic              pick, pick_ok;
   logic              strb, xfer;

   assign req  = {m1.req, m0.req};
   assign we   = {m1.we,  m0.we};
   assign rd   = {m1.rd,  m0.rd};
   assign a[0] = m0.a;
   assign a[1] = m1.a;
   assign d[0] = m0.d;
   assign d[1] = m1.d;

   assign m0.gnt   = gnt[0];
   assign m1.gnt   = gnt[1];
   assign m0.hrd   = hrd[0];
   assign m1.hrd   = hrd[1];
   assign m0.ready = ready[0];
   assign m1.ready = ready[1];
   // Read data is broadcast; only ready is gated per owner.
   assign m0.spo   = s.spo;
   assign m1.spo   = s.spo;

   rr_pick2 u_pick (
      .req    (req),
      .last   (last),
      .winner (pick),
      .valid  (pick_ok)
   );

   assign strb = rd[owner] | we[owner];
   assign xfer = strb & s.gnt & s.ready;

   // Saturating count of completed transfers by the owner.
   assign cnt_inc = (xfer && cnt != CAP) ? cnt + ONE : cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         last  <= 1'b1;
         owner <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         owner <= owner_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      owner_nxt = owner;
      cnt_nxt   = cnt;
      gnt       = '0;
      hrd       = '0;
      ready     = '0;
      s.req     = 1'b0;
      s.a       = '0;
      s.d       = '0;
      s.we      = 1'b0;
      s.rd      = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (pick_ok) begin
               owner_nxt = pick;
               cnt_nxt   = '0;
               state_nxt = pick ? ST_OWN1 : ST_OWN0;
            end
         end

         ST_OWN0, ST_OWN1: begin
            gnt[owner]   = s.gnt;
            hrd[owner]   = s.hrd;
            hrd[~owner]  = 1'b1;
            ready[owner] = s.ready;
            s.req        = req[owner];
            s.a          = a[owner];
            s.d          = d[owner];
            s.we         = we[owner];
            s.rd         = rd[owner];
            cnt_nxt      = cnt_inc;
            // A voluntary release beats the fairness cap.
            if (!req[owner] && !strb) begin
               last_nxt  = owner;
               cnt_nxt   = '0;
               state_nxt = ST_IDLE;
            // Leave only between transfers so nothing is cut.
            end else if (req[~owner] && cnt_inc == CAP
                         && (!strb || xfer)) begin
               state_nxt = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            hrd       = 2'b11;
            s.a       = a[owner];
            s.d       = d[owner];
            last_nxt  = owner;
            owner_nxt = ~owner;
            cnt_nxt   = '0;
            state_nxt = owner ? ST_OWN0 : ST_OWN1;
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// tb_mmu_bus_arbiter: directed self-checking bench for mmu_bus_arbiter.
// Drives two MMU masters and a simple auto-ready downstream slave.
`timescale 1ns/100ps
module tb_mmu_bus_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic auto_rdy = 1'b1;
   int   errs = 0;
   int   checks = 0;

   mmu_bus_arbiter_if i_m0 ();
   mmu_bus_arbiter_if i_m1 ();
   mmu_bus_arbiter_if i_s ();

   always #5 clk = ~clk;

   // Downstream slave: returns ~address, completes strobes instantly.
   assign i_s.spo   = ~i_s.a;
   assign i_s.ready = auto_rdy ? (i_s.rd | i_s.we) : 1'b0;

   mmu_bus_arbiter #(.MAX_XFER(8), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m0    (i_m0),
      .m1    (i_m1),
      .s     (i_s)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      i_m0.req = 1'b1; i_m1.req = 1'b1;
      i_m0.a = 32'h8000_0010; i_m1.a = 32'h9000_0020;
      i_m0.d = 32'h0; i_m1.d = 32'h0;
      i_m0.rd = 1'b0; i_m1.rd = 1'b0;
      i_m0.we = 1'b0; i_m1.we = 1'b0;
      i_s.gnt = 1'b1; i_s.hrd = 1'b0;
      rst_n = 1'b0;
      #3;
      checks++;
      if ({i_m0.gnt, i_m1.gnt, i_m0.ready, i_m1.ready} !== 4'b0) begin
         errs++;
         $display("FAIL rst_gnt_rdy: got %b want 0000",
            {i_m0.gnt, i_m1.gnt, i_m0.ready, i_m1.ready});
      end
      repeat (2) tick;
      checks++;
      if ({i_s.req, i_s.we, i_s.rd, i_m0.hrd, i_m1.hrd} !== 5'b0) begin
         errs++;
         $display("FAIL rst_s_ctl: got %b want 00000",
            {i_s.req, i_s.we, i_s.rd, i_m0.hrd, i_m1.hrd});
      end
      checks++;
      if ({i_s.a, i_s.d} !== 64'h0) begin
         errs++;
         $display("FAIL rst_s_ad: got %h want 0", {i_s.a, i_s.d});
      end
      rst_n = 1'b1;
      tick;
      checks++;
      if (i_s.a !== 32'h8000_0010 || i_m0.gnt !== 1'b1) begin
         errs++;
         $display("FAIL rst_m0_first: got a=%h gnt=%b want 80000010 1",
            i_s.a, i_m0.gnt);
      end
      checks++;
      if (i_m1.gnt !== 1'b0 || i_m1.hrd !== 1'b1) begin
         errs++;
         $display("FAIL rst_m1_wait: got gnt=%b hrd=%b want 0 1",
            i_m1.gnt, i_m1.hrd);
      end
      i_m0.req = 1'b0; i_m1.req = 1'b0;
      tick;
   endtask

   task automatic test_tiebreak;
      i_m0.req = 1'b1; i_m1.req = 1'b1;
      tick;
      checks++;
      if (i_m1.gnt !== 1'b1 || i_s.a !== 32'h9000_0020) begin
         errs++;
         $display("FAIL tie_last0: got gnt1=%b a=%h want 1 90000020",
            i_m1.gnt, i_s.a);
      end
      i_m1.req = 1'b0;
      tick;
      checks++;
      if ({i_m0.gnt, i_m1.gnt} !== 2'b00) begin
         errs++;
         $display("FAIL tie_idle: got %b want 00", {i_m0.gnt, i_m1.gnt});
      end
      i_m1.req = 1'b1;
      tick;
      checks++;
      if (i_m0.gnt !== 1'b1 || i_s.a !== 32'h8000_0010) begin
         errs++;
         $display("FAIL tie_last1: got gnt0=%b a=%h want 1 80000010",
            i_m0.gnt, i_s.a);
      end
      i_m0.req = 1'b0; i_m1.req = 1'b0;
      tick;
   endtask

   task automatic test_sticky;
      logic [31:0] addr [3];
      addr[0] = 32'h0001_1000;
      addr[1] = 32'h0002_2004;
      addr[2] = 32'h0003_3008;
      i_m1.req = 1'b1;
      tick;
      i_m0.req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_m1.a = addr[i];
         i_m1.rd = 1'b1;
         #1;
         checks++;
         if (i_m1.gnt !== 1'b1 || i_m1.ready !== 1'b1
             || i_m0.ready !== 1'b0) begin
            errs++;
            $display("FAIL sticky_own%0d: got g1=%b r1=%b r0=%b want 1 1 0",
               i, i_m1.gnt, i_m1.ready, i_m0.ready);
         end
         checks++;
         if (i_s.a !== addr[i] || i_m1.spo !== ~addr[i]
             || i_m0.spo !== ~addr[i]) begin
            errs++;
            $display("FAIL sticky_data%0d: got a=%h spo=%h want %h %h",
               i, i_s.a, i_m1.spo, addr[i], ~addr[i]);
         end
         tick;
      end
      i_m1.rd = 1'b0; i_m1.req = 1'b0;
      tick;
      checks++;
      if (i_m0.gnt !== 1'b0) begin
         errs++;
         $display("FAIL sticky_arb: got gnt0=%b want 0", i_m0.gnt);
      end
      tick;
      checks++;
      if (i_m0.gnt !== 1'b1) begin
         errs++;
         $display("FAIL sticky_handoff: got gnt0=%b want 1", i_m0.gnt);
      end
   endtask

   task automatic test_fairness;
      int pulses = 0;
      int drains = 0;
      bit done = 0;
      i_m1.req = 1'b1;
      i_m0.a = 32'h8000_0100;
      i_m0.rd = 1'b1;
      for (int i = 0; i < 30 && !done; i++) begin
         #1;
         if (i_m0.ready) pulses++;
         if (i_m0.hrd && !i_m1.gnt) drains++;
         if (i_m1.gnt) done = 1;
         else tick;
      end
      checks++;
      if (!done) begin
         errs++;
         $display("FAIL fair_timeout: got no handoff want handoff");
      end
      checks++;
      if (pulses != 8 || drains != 1) begin
         errs++;
         $display("FAIL fair_cap: got pulses=%0d drains=%0d want 8 1",
            pulses, drains);
      end
      checks++;
      if (i_s.rd !== 1'b0 || i_m0.ready !== 1'b0) begin
         errs++;
         $display("FAIL fair_ignore: got rd=%b r0=%b want 0 0",
            i_s.rd, i_m0.ready);
      end
      i_m0.rd = 1'b0; i_m0.req = 1'b0;
   endtask

   task automatic test_hold;
      auto_rdy = 1'b0;
      i_s.hrd = 1'b1;
      #1;
      checks++;
      if ({i_m1.gnt, i_m1.hrd, i_m0.hrd} !== 3'b111) begin
         errs++;
         $display("FAIL hold_on: got %b want 111",
            {i_m1.gnt, i_m1.hrd, i_m0.hrd});
      end
      repeat (3) tick;
      checks++;
      if (i_m1.gnt !== 1'b1 || i_m1.hrd !== 1'b1) begin
         errs++;
         $display("FAIL hold_owner: got gnt=%b hrd=%b want 1 1",
            i_m1.gnt, i_m1.hrd);
      end
      i_s.hrd = 1'b0;
      #1;
      checks++;
      if (i_m1.hrd !== 1'b0) begin
         errs++;
         $display("FAIL hold_off: got hrd1=%b want 0", i_m1.hrd);
      end
      auto_rdy = 1'b1;
   endtask

   task automatic test_async_reset;
      int pulses = 0;
      int drains = 0;
      bit done = 0;
      i_m1.d = 32'hDEAD_BEEF;
      i_m1.we = 1'b1;
      repeat (3) tick;
      auto_rdy = 1'b0;
      #1;
      checks++;
      if (i_s.we !== 1'b1 || i_s.d !== 32'hDEAD_BEEF) begin
         errs++;
         $display("FAIL ar_pre: got we=%b d=%h want 1 deadbeef",
            i_s.we, i_s.d);
      end
      #1;
      rst_n = 1'b0;
      #0.1;
      checks++;
      if ({i_s.we, i_s.req, i_m1.gnt} !== 3'b000) begin
         errs++;
         $display("FAIL ar_drop: got %b want 000",
            {i_s.we, i_s.req, i_m1.gnt});
      end
      i_m1.we = 1'b0; i_m1.req = 1'b0;
      i_m0.req = 1'b1;
      auto_rdy = 1'b1;
      tick;
      rst_n = 1'b1;
      tick;
      checks++;
      if (i_m0.gnt !== 1'b1) begin
         errs++;
         $display("FAIL ar_idle: got gnt0=%b want 1", i_m0.gnt);
      end
      i_m1.req = 1'b1;
      i_m0.rd = 1'b1;
      for (int i = 0; i < 30 && !done; i++) begin
         #1;
         if (i_m0.ready) pulses++;
         if (i_m0.hrd && !i_m1.gnt) drains++;
         if (i_m1.gnt) done = 1;
         else tick;
      end
      checks++;
      if (!done || pulses != 8 || drains != 1) begin
         errs++;
         $display("FAIL ar_cnt0: got done=%0d pulses=%0d drains=%0d want 1 8 1",
            done, pulses, drains);
      end
      i_m0.rd = 1'b0; i_m0.req = 1'b0;
   endtask

   task automatic test_solo_cap;
      int pulses = 0;
      int lost = 0;
      i_m1.a = 32'h0004_4000;
      i_m1.rd = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (i_m1.ready) pulses++;
         if (!i_m1.gnt) lost++;
         tick;
      end
      checks++;
      if (pulses != 12 || lost != 0) begin
         errs++;
         $display("FAIL solo: got pulses=%0d lost=%0d want 12 0",
            pulses, lost);
      end
      i_m1.rd = 1'b0; i_m1.req = 1'b0;
      i_m0.req = 1'b1;
      tick;
      checks++;
      if ({i_m0.hrd, i_m1.hrd, i_m0.gnt, i_m1.gnt} !== 4'b0) begin
         errs++;
         $display("FAIL drop_vs_cap: got %b want 0000",
            {i_m0.hrd, i_m1.hrd, i_m0.gnt, i_m1.gnt});
      end
      tick;
      checks++;
      if (i_m0.gnt !== 1'b1) begin
         errs++;
         $display("FAIL drop_regrant: got gnt0=%b want 1", i_m0.gnt);
      end
   endtask

   initial begin
      test_reset;
      test_tiebreak;
      test_sticky;
      test_fairness;
      test_hold;
      test_async_reset;
      test_solo_cap;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
